// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice: opcodes, FSM states,
// ALU operation and ALU B-operand select codes.
package mc_control_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_LUIEX  = 4'd9,
    S_LUIWB  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_lui;
    logic is_illegal;
  } op_dec_t;

  // States that issue a memory access and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_op_decode.sv
// Opcode classifier: exact compares to a one-hot instruction class.
// Also used by the instruction tracer.
module mc_op_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] i_op,
  output op_dec_t    o_dec
);

  always_comb begin
    o_dec            = '0;
    o_dec.is_r       = (i_op == OP_R);
    o_dec.is_lw      = (i_op == OP_LW);
    o_dec.is_sw      = (i_op == OP_SW);
    o_dec.is_beq     = (i_op == OP_BEQ);
    o_dec.is_lui     = (i_op == OP_LUI);
    o_dec.is_illegal = !(o_dec.is_r | o_dec.is_lw | o_dec.is_sw |
                         o_dec.is_beq | o_dec.is_lui);
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the shared-memory MIPS datapath (R, lw, sw, beq, lui)
// with memory ready handshake, wait-state timeout and per-instruction retire strobe.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       PCSource,
  output logic [1:0] ALUctr,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  op_dec_t          w_dec;
  logic             w_wait;
  logic             w_timeout;

  mc_op_decode u_dec (
    .i_op  (op),
    .o_dec (w_dec)
  );

  assign w_wait    = is_mem_state(r_state) && !mem_ready;
  assign w_timeout = w_wait && (r_cnt == CNT_W'(WAIT_MAX));
  assign state_dbg = r_state;

  // A timeout in FETCH keeps the state, so it clears the counter explicitly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout)
        r_cnt <= '0;
      else if (w_wait)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    PCSource    = 1'b0;
    ALUctr      = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)
          w_next = S_DECODE;
        else if (w_timeout)
          mem_err = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        if (w_dec.is_lw || w_dec.is_sw) w_next = S_MEMADR;
        else if (w_dec.is_r)            w_next = S_EXEC;
        else if (w_dec.is_beq)          w_next = S_BRANCH;
        else if (w_dec.is_lui)          w_next = S_LUIEX;
        else begin
          illegal_op = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (w_dec.is_lw)      w_next = S_MEMRD;
        else if (w_dec.is_sw) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
        else if (w_timeout) begin
          mem_err = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_timeout) begin
          mem_err = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUctr  = ALU_FUNCT;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUctr      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_LUIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUctr  = ALU_LUI;
        w_next  = S_LUIWB;
      end
      S_LUIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset masks every strobe so an abandoned access never writes.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = '0;
      PCSource    = 1'b0;
      ALUctr      = '0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_err     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed vector table for the instruction sequences and
// corner cases, then randomized traffic against a step-list reference model.
module tb_mc_control;

  localparam int unsigned WMAX = 3;
  localparam logic [5:0] T_R   = 6'h00;
  localparam logic [5:0] T_LW  = 6'h23;
  localparam logic [5:0] T_SW  = 6'h2B;
  localparam logic [5:0] T_BEQ = 6'h04;
  localparam logic [5:0] T_LUI = 6'h0F;
  localparam logic [5:0] T_BAD = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready;
  logic [5:0] op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, PCSource;
  logic [1:0] ALUSrcB, ALUctr;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state_dbg;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mc_control #(.WAIT_MAX(WMAX), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUctr(ALUctr), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // ctl = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, illegal_op, mem_err}
  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [7:0] ctl;
    logic [1:0] alu;
    logic       pcwc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [5:0] o, input logic d,
                              input logic [3:0] s, input logic [7:0] c,
                              input logic [1:0] a, input logic p);
    vec_t v;
    v = '{r, o, d, s, c, a, p};
    tbl.push_back(v);
  endfunction

  // Reference model: current step plus the remaining step list of the instruction.
  int m_step;
  int m_wcnt;
  int m_rest[$];

  function automatic logic [17:0] model_out(input int s, input logic rdy, input logic rst,
                                            input logic tmo, input logic illg);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, pcs, idn, ill, merr;
    logic [1:0] srcb, alu;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, pcs, idn, ill, merr} = '0;
    srcb = 2'b00;
    alu  = 2'b00;
    case (s)
      0:  begin mr = 1; srcb = 2'b01; pcw = rdy; irw = rdy; merr = tmo; end
      1:  begin srcb = 2'b11; ill = illg; end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mr = 1; iord = 1; merr = tmo; end
      4:  begin rw = 1; m2r = 1; idn = 1; end
      5:  begin mw = 1; iord = 1; idn = rdy; merr = tmo; end
      6:  begin srca = 1; alu = 2'b10; end
      7:  begin rw = 1; rdst = 1; idn = 1; end
      8:  begin srca = 1; alu = 2'b01; pcwc = 1; pcs = 1; idn = 1; end
      9:  begin srca = 1; srcb = 2'b10; alu = 2'b11; end
      10: begin rw = 1; idn = 1; end
      default: ;
    endcase
    if (!rst) return '0;
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, pcs, alu, idn, ill, merr};
  endfunction

  function automatic logic mem_step(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  task automatic model_advance();
    if (!rst_n) begin
      m_step = 0; m_wcnt = 0; m_rest.delete();
    end else if (mem_step(m_step) && !mem_ready) begin
      if (m_wcnt == int'(WMAX)) begin
        m_step = 0; m_wcnt = 0; m_rest.delete();
      end else m_wcnt++;
    end else begin
      m_wcnt = 0;
      if (m_step == 0) m_step = 1;
      else begin
        if (m_step == 1) begin
          case (op)
            T_LW:    m_rest = '{2, 3, 4};
            T_SW:    m_rest = '{2, 5};
            T_R:     m_rest = '{6, 7};
            T_BEQ:   m_rest = '{8};
            T_LUI:   m_rest = '{9, 10};
            default: m_rest.delete();
          endcase
        end
        if (m_rest.size() == 0) m_step = 0;
        else m_step = m_rest.pop_front();
      end
    end
  endtask

  initial begin
    logic [7:0]  act_ctl;
    logic [17:0] exp_o, act_o;
    logic        tmo, illg;

    rst_n = 1'b0; op = T_LW; mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    add(0, T_LW, 1, 0, 8'h00, 2'b00, 0);
    // lw, zero wait
    add(1, T_LW, 1, 0, 8'hE0, 2'b00, 0);
    add(1, T_LW, 1, 1, 8'h00, 2'b00, 0);
    add(1, T_LW, 1, 2, 8'h00, 2'b00, 0);
    add(1, T_LW, 1, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 1, 4, 8'h0C, 2'b00, 0);
    // R, beq, lui back-to-back
    add(1, T_R,   1, 0,  8'hE0, 2'b00, 0);
    add(1, T_R,   1, 1,  8'h00, 2'b00, 0);
    add(1, T_R,   1, 6,  8'h00, 2'b10, 0);
    add(1, T_R,   1, 7,  8'h0C, 2'b00, 0);
    add(1, T_BEQ, 1, 0,  8'hE0, 2'b00, 0);
    add(1, T_BEQ, 1, 1,  8'h00, 2'b00, 0);
    add(1, T_BEQ, 1, 8,  8'h04, 2'b01, 1);
    add(1, T_LUI, 1, 0,  8'hE0, 2'b00, 0);
    add(1, T_LUI, 1, 1,  8'h00, 2'b00, 0);
    add(1, T_LUI, 1, 9,  8'h00, 2'b11, 0);
    add(1, T_LUI, 1, 10, 8'h0C, 2'b00, 0);
    // illegal opcode
    add(1, T_BAD, 1, 0, 8'hE0, 2'b00, 0);
    add(1, T_BAD, 1, 1, 8'h02, 2'b00, 0);
    // sw with three wait cycles
    add(1, T_SW, 1, 0, 8'hE0, 2'b00, 0);
    add(1, T_SW, 1, 1, 8'h00, 2'b00, 0);
    add(1, T_SW, 1, 2, 8'h00, 2'b00, 0);
    add(1, T_SW, 0, 5, 8'h10, 2'b00, 0);
    add(1, T_SW, 0, 5, 8'h10, 2'b00, 0);
    add(1, T_SW, 0, 5, 8'h10, 2'b00, 0);
    add(1, T_SW, 1, 5, 8'h14, 2'b00, 0);
    // lw read timeout at the fourth MEMRD cycle
    add(1, T_LW, 1, 0, 8'hE0, 2'b00, 0);
    add(1, T_LW, 1, 1, 8'h00, 2'b00, 0);
    add(1, T_LW, 1, 2, 8'h00, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h21, 2'b00, 0);
    // ready on the limit cycle: completion wins
    add(1, T_LW, 1, 0, 8'hE0, 2'b00, 0);
    add(1, T_LW, 1, 1, 8'h00, 2'b00, 0);
    add(1, T_LW, 1, 2, 8'h00, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 0, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 1, 3, 8'h20, 2'b00, 0);
    add(1, T_LW, 1, 4, 8'h0C, 2'b00, 0);
    // reset held two cycles in MEMWR
    add(1, T_SW, 1, 0, 8'hE0, 2'b00, 0);
    add(1, T_SW, 1, 1, 8'h00, 2'b00, 0);
    add(1, T_SW, 1, 2, 8'h00, 2'b00, 0);
    add(1, T_SW, 0, 5, 8'h10, 2'b00, 0);
    add(0, T_SW, 0, 5, 8'h00, 2'b00, 0);
    add(0, T_SW, 0, 0, 8'h00, 2'b00, 0);
    add(1, T_SW, 0, 0, 8'h20, 2'b00, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst; op = tbl[i].op; mem_ready = tbl[i].rdy;
      #1;
      act_ctl = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, illegal_op, mem_err};
      n_vec++;
      if ({state_dbg, act_ctl, ALUctr, PCWriteCond} !==
          {tbl[i].st, tbl[i].ctl, tbl[i].alu, tbl[i].pcwc}) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%0d ctl=%h alu=%b pcwc=%b, want st=%0d ctl=%h alu=%b pcwc=%b",
                 i, state_dbg, act_ctl, ALUctr, PCWriteCond,
                 tbl[i].st, tbl[i].ctl, tbl[i].alu, tbl[i].pcwc);
      end
    end

    // Randomized traffic, starting from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_step = 0; m_wcnt = 0; m_rest.delete();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      mem_ready = ($urandom_range(0, 99) < 55);
      if (m_step == 0) begin
        case ($urandom_range(0, 5))
          0: op = T_R;
          1: op = T_LW;
          2: op = T_SW;
          3: op = T_BEQ;
          4: op = T_LUI;
          default: op = 6'($urandom);
        endcase
      end
      #1;
      tmo   = mem_step(m_step) && !mem_ready && (m_wcnt == int'(WMAX));
      illg  = !(op inside {T_R, T_LW, T_SW, T_BEQ, T_LUI});
      exp_o = model_out(m_step, mem_ready, rst_n, tmo, illg);
      act_o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUctr, instr_done, illegal_op, mem_err};
      n_vec++;
      if (act_o !== exp_o || state_dbg !== 4'(m_step)) begin
        n_bad++;
        $display("FAIL rand%0d: got st=%0d out=%b, want st=%0d out=%b (op=%h rdy=%b rst_n=%b)",
                 cyc, state_dbg, act_o, m_step, exp_o, op, mem_ready, rst_n);
      end
      model_advance();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
